// File: rtl/id_exe_stage_if.sv
// ID->EXE stage bus: upstream ID/forwarding inputs and registered EXE outputs.
// The master drives the ID side; the slave is the pipeline register itself.
interface id_exe_stage_if #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
);
  logic               stall;
  logic               flush;
  logic [1:0]         rd1c;
  logic [1:0]         rd2c;
  logic [DATA_W-1:0]  rf_rd1;
  logic [DATA_W-1:0]  rf_rd2;
  logic [DATA_W-1:0]  alu_res_exe;
  logic [DATA_W-1:0]  alu_res_mem;
  logic [DATA_W-1:0]  dmem_rd_mem;
  logic [DATA_W-1:0]  imm_id;
  logic [DATA_W-1:0]  pc_id;
  logic               wrf_id;
  logic               wdc_id;
  logic               aludc_id;
  logic [4:0]         wa_id;
  logic [ALUOP_W-1:0] aluop_id;

  logic [DATA_W-1:0]  op_a_exe;
  logic [DATA_W-1:0]  op_b_exe;
  logic [DATA_W-1:0]  imm_exe;
  logic [DATA_W-1:0]  pc_exe;
  logic               wrf_exe;
  logic               wdc_exe;
  logic               aludc_exe;
  logic [4:0]         wa_exe;
  logic [ALUOP_W-1:0] aluop_exe;
  logic               valid_exe;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output stall, flush, rd1c, rd2c, rf_rd1, rf_rd2,
           alu_res_exe, alu_res_mem, dmem_rd_mem, imm_id, pc_id,
           wrf_id, wdc_id, aludc_id, wa_id, aluop_id,
    input  op_a_exe, op_b_exe, imm_exe, pc_exe, wrf_exe, wdc_exe,
           aludc_exe, wa_exe, aluop_exe, valid_exe, bubble_cnt
  );

  modport slave (
    input  stall, flush, rd1c, rd2c, rf_rd1, rf_rd2,
           alu_res_exe, alu_res_mem, dmem_rd_mem, imm_id, pc_id,
           wrf_id, wdc_id, aludc_id, wa_id, aluop_id,
    output op_a_exe, op_b_exe, imm_exe, pc_exe, wrf_exe, wdc_exe,
           aludc_exe, wa_exe, aluop_exe, valid_exe, bubble_cnt
  );
endinterface

// File: rtl/id_exe_stage.sv
// ID->EXE pipeline register with operand forwarding mux and bubble insertion.
// A stall or flush (or both) loads a single bubble; the stage never holds its
// own contents, upstream holds the ID instruction during a stall.
module id_exe_stage #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          rst,
  id_exe_stage_if.slave bus
);

  logic [DATA_W-1:0]  op_a_sel;
  logic [DATA_W-1:0]  op_b_sel;
  logic               bubble;

  logic [DATA_W-1:0]  op_a_q,  op_a_d;
  logic [DATA_W-1:0]  op_b_q,  op_b_d;
  logic [DATA_W-1:0]  imm_q,   imm_d;
  logic [DATA_W-1:0]  pc_q,    pc_d;
  logic               wrf_q,   wrf_d;
  logic               wdc_q,   wdc_d;
  logic               aludc_q, aludc_d;
  logic [4:0]         wa_q,    wa_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  // Forwarding mux for rs: 00 rf, 01 EXE alu, 10 MEM alu, 11 MEM dmem
  always_comb begin
    op_a_sel = bus.rf_rd1;
    unique case (bus.rd1c)
      2'b00: op_a_sel = bus.rf_rd1;
      2'b01: op_a_sel = bus.alu_res_exe;
      2'b10: op_a_sel = bus.alu_res_mem;
      2'b11: op_a_sel = bus.dmem_rd_mem;
      default: op_a_sel = bus.rf_rd1;
    endcase
  end

  // Forwarding mux for rt, same encoding as rs
  always_comb begin
    op_b_sel = bus.rf_rd2;
    unique case (bus.rd2c)
      2'b00: op_b_sel = bus.rf_rd2;
      2'b01: op_b_sel = bus.alu_res_exe;
      2'b10: op_b_sel = bus.alu_res_mem;
      2'b11: op_b_sel = bus.dmem_rd_mem;
      default: op_b_sel = bus.rf_rd2;
    endcase
  end

  assign bubble = bus.flush | bus.stall;

  // Next-state: bubble zeroes the slot, otherwise load the ID instruction
  always_comb begin
    op_a_d  = '0;
    op_b_d  = '0;
    imm_d   = '0;
    pc_d    = '0;
    wrf_d   = 1'b0;
    wdc_d   = 1'b0;
    aludc_d = 1'b0;
    wa_d    = '0;
    aluop_d = '0;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (bubble) begin
      // Saturate rather than wrap so a long stall run stays visible
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      op_a_d  = op_a_sel;
      op_b_d  = op_b_sel;
      imm_d   = bus.imm_id;
      pc_d    = bus.pc_id;
      wrf_d   = bus.wrf_id;
      wdc_d   = bus.wdc_id;
      aludc_d = bus.aludc_id;
      wa_d    = bus.wa_id;
      aluop_d = bus.aluop_id;
      valid_d = 1'b1;
    end
  end

  // Stage register with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      wrf_q   <= 1'b0;
      wdc_q   <= 1'b0;
      aludc_q <= 1'b0;
      wa_q    <= '0;
      aluop_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      wrf_q   <= wrf_d;
      wdc_q   <= wdc_d;
      aludc_q <= aludc_d;
      wa_q    <= wa_d;
      aluop_q <= aluop_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.op_a_exe   = op_a_q;
  assign bus.op_b_exe   = op_b_q;
  assign bus.imm_exe    = imm_q;
  assign bus.pc_exe     = pc_q;
  assign bus.wrf_exe    = wrf_q;
  assign bus.wdc_exe    = wdc_q;
  assign bus.aludc_exe  = aludc_q;
  assign bus.wa_exe     = wa_q;
  assign bus.aluop_exe  = aluop_q;
  assign bus.valid_exe  = valid_q;
  assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// Bench for id_exe_stage: reference model of the stage plus directed literal checks.
module tb_id_exe_stage;
  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_exe_stage_if #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  id_exe_stage #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the EXE slot must hold after each edge
  logic [DATA_W-1:0]  m_a, m_b, m_imm, m_pc;
  logic               m_wrf, m_wdc, m_aludc, m_valid;
  logic [4:0]         m_wa;
  logic [ALUOP_W-1:0] m_aluop;
  int unsigned        m_cnt;
  bit                 m_ready = 1'b0;

  always @(posedge clk) begin
    logic [DATA_W-1:0] src_a [4];
    logic [DATA_W-1:0] src_b [4];
    src_a = '{bus.rf_rd1, bus.alu_res_exe, bus.alu_res_mem, bus.dmem_rd_mem};
    src_b = '{bus.rf_rd2, bus.alu_res_exe, bus.alu_res_mem, bus.dmem_rd_mem};
    if (rst) begin
      m_ready = 1'b1;
      {m_a, m_b, m_imm, m_pc, m_wrf, m_wdc, m_aludc, m_wa, m_aluop, m_valid} = '0;
      m_cnt = 0;
    end else if (bus.flush || bus.stall) begin
      {m_a, m_b, m_imm, m_pc, m_wrf, m_wdc, m_aludc, m_wa, m_aluop, m_valid} = '0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_a = src_a[bus.rd1c];
      m_b = src_b[bus.rd2c];
      m_imm = bus.imm_id;
      m_pc = bus.pc_id;
      m_wrf = bus.wrf_id;
      m_wdc = bus.wdc_id;
      m_aludc = bus.aludc_id;
      m_wa = bus.wa_id;
      m_aluop = bus.aluop_id;
      m_valid = 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_ready) begin
      check("op_a", 64'(bus.op_a_exe), 64'(m_a));
      check("op_b", 64'(bus.op_b_exe), 64'(m_b));
      check("imm", 64'(bus.imm_exe), 64'(m_imm));
      check("pc", 64'(bus.pc_exe), 64'(m_pc));
      check("ctrl", 64'({bus.wrf_exe, bus.wdc_exe, bus.aludc_exe, bus.valid_exe}),
            64'({m_wrf, m_wdc, m_aludc, m_valid}));
      check("wa", 64'(bus.wa_exe), 64'(m_wa));
      check("aluop", 64'(bus.aluop_exe), 64'(m_aluop));
      check("bubble_cnt", 64'(bus.bubble_cnt), 64'(m_cnt));
    end
  end

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0; bus.rd1c = 0; bus.rd2c = 0;
    bus.rf_rd1 = 0; bus.rf_rd2 = 0; bus.alu_res_exe = 0; bus.alu_res_mem = 0;
    bus.dmem_rd_mem = 0; bus.imm_id = 0; bus.pc_id = 0; bus.wrf_id = 0;
    bus.wdc_id = 0; bus.aludc_id = 0; bus.wa_id = 0; bus.aluop_id = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    check("rst_valid", 64'(bus.valid_exe), 64'd0);
    check("rst_cnt", 64'(bus.bubble_cnt), 64'd0);
    check("rst_op_a", 64'(bus.op_a_exe), 64'd0);
    rst = 0;

    // Plain register-file operands
    bus.rf_rd1 = 32'h11; bus.rf_rd2 = 32'h22; bus.wa_id = 5; bus.wrf_id = 1;
    bus.alu_res_exe = 32'hA; bus.alu_res_mem = 32'hB; bus.dmem_rd_mem = 32'hD;
    cyc();
    check("t2_op_a", 64'(bus.op_a_exe), 64'h11);
    check("t2_op_b", 64'(bus.op_b_exe), 64'h22);
    check("t2_wa", 64'(bus.wa_exe), 64'd5);
    check("t2_wrf", 64'(bus.wrf_exe), 64'd1);
    check("t2_valid", 64'(bus.valid_exe), 64'd1);

    // Forwarded operands
    bus.rd1c = 2'b01; bus.rd2c = 2'b11;
    cyc();
    check("t3_op_a", 64'(bus.op_a_exe), 64'hA);
    check("t3_op_b_dmem", 64'(bus.op_b_exe), 64'hD);
    bus.rd2c = 2'b10;
    cyc();
    check("t3_op_b_mem", 64'(bus.op_b_exe), 64'hB);

    // Stall then reload of the held ID instruction
    bus.stall = 1; bus.wdc_id = 1;
    cyc();
    check("t4_valid", 64'(bus.valid_exe), 64'd0);
    check("t4_wdc", 64'(bus.wdc_exe), 64'd0);
    check("t4_wrf", 64'(bus.wrf_exe), 64'd0);
    check("t4_cnt", 64'(bus.bubble_cnt), 64'd1);
    bus.stall = 0;
    cyc();
    check("t4_reload_valid", 64'(bus.valid_exe), 64'd1);
    check("t4_reload_wdc", 64'(bus.wdc_exe), 64'd1);

    // Stall and flush together count once
    bus.stall = 1; bus.flush = 1;
    cyc();
    check("t5_cnt", 64'(bus.bubble_cnt), 64'd2);
    check("t5_valid", 64'(bus.valid_exe), 64'd0);
    bus.stall = 0; bus.flush = 0;

    // Randomized traffic including occasional mid-stream reset
    for (int i = 0; i < 600; i++) begin
      bus.stall = ($urandom_range(3) == 0);
      bus.flush = ($urandom_range(4) == 0);
      bus.rd1c = 2'($urandom); bus.rd2c = 2'($urandom);
      bus.rf_rd1 = $urandom; bus.rf_rd2 = $urandom;
      bus.alu_res_exe = $urandom; bus.alu_res_mem = $urandom;
      bus.dmem_rd_mem = $urandom; bus.imm_id = $urandom; bus.pc_id = $urandom;
      bus.wrf_id = 1'($urandom); bus.wdc_id = 1'($urandom);
      bus.aludc_id = 1'($urandom); bus.wa_id = 5'($urandom);
      bus.aluop_id = 4'($urandom);
      rst = ($urandom_range(63) == 0);
      cyc();
    end
    rst = 0;

    // Saturation from a cleared counter
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;
    bus.stall = 1;
    for (int i = 0; i < 65535; i++) cyc();
    check("t6_cnt_max", 64'(bus.bubble_cnt), 64'hFFFF);
    cyc();
    check("t6_cnt_sat", 64'(bus.bubble_cnt), 64'hFFFF);
    bus.stall = 0;
    rst = 1;
    cyc();
    check("t6_cnt_rst", 64'(bus.bubble_cnt), 64'd0);
    rst = 0;
    bus.wrf_id = 1; bus.wa_id = 0;
    cyc();
    check("r0_wrf", 64'(bus.wrf_exe), 64'd1);
    check("post_rst_valid", 64'(bus.valid_exe), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
